// File: rtl/cp0_exc_pkg.sv
// ============================================================================
// Module  : cp0_exc_pkg
// Brief   : Shared cause codes, STATUS bit indices and FSM states for the
//           CP0 exception sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_exc_pkg;

  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;
  localparam logic [4:0] CAUSE_NONE    = 5'b00000;

  localparam int IE     = 0;
  localparam int SYS_EN = 1;
  localparam int BRK_EN = 2;
  localparam int TEQ_EN = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_VECTOR = 2'd2,
    ST_ERET   = 2'd3
  } exc_state_t;

endpackage

`default_nettype wire

// File: rtl/cp0_exc_ctrl_if.sv
// ============================================================================
// Module  : cp0_exc_ctrl_if
// Brief   : Decode/CP0/PC-unit bundle for the exception sequencer.
//           Optional stats ports with CP0_EXC_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp0_exc_ctrl_if #(
  parameter int PC_W = 32
);
  logic            i_inst_valid;
  logic            i_is_syscall;
  logic            i_is_break;
  logic            i_is_teq;
  logic            i_is_eret;
  logic [PC_W-1:0] i_rs_val;
  logic [PC_W-1:0] i_rt_val;
  logic [PC_W-1:0] i_pc_in;
  logic [PC_W-1:0] i_status_in;
  logic [PC_W-1:0] i_epc_in;
  logic [4:0]      o_cause;
  logic [PC_W-1:0] o_exc_pc;
  logic            o_eret;
  logic            o_cp0_ena;
  logic            o_stall;
  logic            o_redirect;
  logic [PC_W-1:0] o_redirect_pc;
  logic [2:0]      o_depth;
  logic            o_ovf;
`ifdef CP0_EXC_STATS_EN
  logic [1:0]      i_stat_sel;
  logic [15:0]     o_stat_q;

  modport master (
    output i_inst_valid, i_is_syscall, i_is_break, i_is_teq, i_is_eret,
           i_rs_val, i_rt_val, i_pc_in, i_status_in, i_epc_in, i_stat_sel,
    input  o_cause, o_exc_pc, o_eret, o_cp0_ena, o_stall, o_redirect,
           o_redirect_pc, o_depth, o_ovf, o_stat_q
  );
  modport slave (
    input  i_inst_valid, i_is_syscall, i_is_break, i_is_teq, i_is_eret,
           i_rs_val, i_rt_val, i_pc_in, i_status_in, i_epc_in, i_stat_sel,
    output o_cause, o_exc_pc, o_eret, o_cp0_ena, o_stall, o_redirect,
           o_redirect_pc, o_depth, o_ovf, o_stat_q
  );
`else
  modport master (
    output i_inst_valid, i_is_syscall, i_is_break, i_is_teq, i_is_eret,
           i_rs_val, i_rt_val, i_pc_in, i_status_in, i_epc_in,
    input  o_cause, o_exc_pc, o_eret, o_cp0_ena, o_stall, o_redirect,
           o_redirect_pc, o_depth, o_ovf
  );
  modport slave (
    input  i_inst_valid, i_is_syscall, i_is_break, i_is_teq, i_is_eret,
           i_rs_val, i_rt_val, i_pc_in, i_status_in, i_epc_in,
    output o_cause, o_exc_pc, o_eret, o_cp0_ena, o_stall, o_redirect,
           o_redirect_pc, o_depth, o_ovf
  );
`endif
endinterface

`default_nettype wire

// File: rtl/cp0_exc_prio.sv
// ============================================================================
// Module  : cp0_exc_prio
// Brief   : Qualifies SYSCALL/BREAK/TEQ against STATUS and picks one cause.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_exc_prio
  import cp0_exc_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            i_is_syscall,
  input  logic            i_is_break,
  input  logic            i_is_teq,
  input  logic [PC_W-1:0] i_rs_val,
  input  logic [PC_W-1:0] i_rt_val,
  input  logic [3:0]      i_status,
  output logic            o_valid,
  output logic [4:0]      o_code
);

  logic w_sys_ok;
  logic w_brk_ok;
  logic w_teq_ok;

  assign w_sys_ok = i_is_syscall & i_status[IE] & i_status[SYS_EN];
  assign w_brk_ok = i_is_break   & i_status[IE] & i_status[BRK_EN];
  assign w_teq_ok = i_is_teq & (i_rs_val == i_rt_val) & i_status[IE] & i_status[TEQ_EN];

  always_comb begin
    o_code = CAUSE_NONE;
    if (w_sys_ok)      o_code = CAUSE_SYSCALL;
    else if (w_brk_ok) o_code = CAUSE_BREAK;
    else if (w_teq_ok) o_code = CAUSE_TEQ;
  end

  assign o_valid = w_sys_ok | w_brk_ok | w_teq_ok;

endmodule

`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
// ============================================================================
// Module  : cp0_exc_ctrl
// Brief   : Exception/ERET sequencer in front of CP0 and the PC unit.
//           Optional cause counters enabled by CP0_EXC_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_exc_ctrl
  import cp0_exc_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = 32'h00400004,
  parameter int          MAX_DEPTH   = 6,
  parameter int          PC_W        = 32
) (
  input  logic            clk,
  input  logic            cp0_rst,
  cp0_exc_ctrl_if.slave   bus
);

  localparam logic [2:0] c_max_depth = 3'(MAX_DEPTH);

  exc_state_t      r_state;
  logic [4:0]      r_code;
  logic [PC_W-1:0] r_pc;
  logic [2:0]      r_depth;
  logic            r_ovf;

  logic            w_valid;
  logic [4:0]      w_code;
  logic            w_idle;
  logic            w_exc_take;
  logic            w_exc_drop;
  logic            w_eret_take;
  logic            w_unused;

  cp0_exc_prio #(.PC_W(PC_W)) u_prio (
    .i_is_syscall (bus.i_is_syscall),
    .i_is_break   (bus.i_is_break),
    .i_is_teq     (bus.i_is_teq),
    .i_rs_val     (bus.i_rs_val),
    .i_rt_val     (bus.i_rt_val),
    .i_status     (bus.i_status_in[3:0]),
    .o_valid      (w_valid),
    .o_code       (w_code)
  );

  assign w_unused    = &{1'b0, bus.i_status_in[PC_W-1:4]};
  assign w_idle      = (r_state == ST_IDLE);
  assign w_exc_take  = w_idle & bus.i_inst_valid & w_valid & (r_depth <  c_max_depth);
  assign w_exc_drop  = w_idle & bus.i_inst_valid & w_valid & (r_depth >= c_max_depth);
  // A qualified exception (even one dropped on overflow) suppresses ERET.
  assign w_eret_take = w_idle & bus.i_inst_valid & bus.i_is_eret & ~w_valid;

  always_ff @(posedge clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      r_state <= ST_IDLE;
      r_code  <= CAUSE_NONE;
      r_pc    <= '0;
      r_depth <= 3'd0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_exc_take) begin
            r_code  <= w_code;
            r_pc    <= bus.i_pc_in;
            r_state <= ST_COMMIT;
          end else if (w_exc_drop) begin
            r_ovf <= 1'b1;
          end else if (w_eret_take) begin
            r_state <= ST_ERET;
          end
        end
        ST_COMMIT: begin
          r_depth <= r_depth + 3'd1;
          r_state <= ST_VECTOR;
        end
        ST_VECTOR: r_state <= ST_IDLE;
        ST_ERET: begin
          if (r_depth != 3'd0) r_depth <= r_depth - 3'd1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_cause     = (r_state == ST_COMMIT) ? r_code : CAUSE_NONE;
  assign bus.o_exc_pc    = (r_state == ST_COMMIT) ? r_pc : '0;
  assign bus.o_eret      = (r_state == ST_ERET);
  assign bus.o_cp0_ena   = (r_state == ST_COMMIT) | (r_state == ST_ERET);
  assign bus.o_redirect  = (r_state == ST_VECTOR) | (r_state == ST_ERET);
  // Same-cycle stall on detect, masked while reset holds the block idle.
  assign bus.o_stall     = ~cp0_rst & (~w_idle | w_exc_take | w_eret_take);
  assign bus.o_depth     = r_depth;
  assign bus.o_ovf       = r_ovf;

  always_comb begin
    bus.o_redirect_pc = '0;
    if (r_state == ST_VECTOR)    bus.o_redirect_pc = PC_W'(VECTOR_ADDR);
    else if (r_state == ST_ERET) bus.o_redirect_pc = bus.i_epc_in;
  end

`ifdef CP0_EXC_STATS_EN
  logic [15:0] r_cnt_sys;
  logic [15:0] r_cnt_brk;
  logic [15:0] r_cnt_teq;
  logic [15:0] r_cnt_drop;

  always_ff @(posedge clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      r_cnt_sys  <= 16'd0;
      r_cnt_brk  <= 16'd0;
      r_cnt_teq  <= 16'd0;
      r_cnt_drop <= 16'd0;
    end else begin
      if (r_state == ST_COMMIT) begin
        if (r_code == CAUSE_SYSCALL && r_cnt_sys != 16'hFFFF) r_cnt_sys <= r_cnt_sys + 16'd1;
        if (r_code == CAUSE_BREAK   && r_cnt_brk != 16'hFFFF) r_cnt_brk <= r_cnt_brk + 16'd1;
        if (r_code == CAUSE_TEQ     && r_cnt_teq != 16'hFFFF) r_cnt_teq <= r_cnt_teq + 16'd1;
      end
      if (w_exc_drop && r_cnt_drop != 16'hFFFF) r_cnt_drop <= r_cnt_drop + 16'd1;
    end
  end

  always_comb begin
    case (bus.i_stat_sel)
      2'd0:    bus.o_stat_q = r_cnt_sys;
      2'd1:    bus.o_stat_q = r_cnt_brk;
      2'd2:    bus.o_stat_q = r_cnt_teq;
      default: bus.o_stat_q = r_cnt_drop;
    endcase
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// ============================================================================
// Module  : tb_cp0_exc_ctrl
// Brief   : Directed self-checking bench for cp0_exc_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_exc_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cp0_exc_ctrl_if #(.PC_W(32)) bus ();

  cp0_exc_ctrl #(
    .VECTOR_ADDR (32'h00400004),
    .MAX_DEPTH   (6),
    .PC_W        (32)
  ) dut (
    .clk     (clk),
    .cp0_rst (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.i_inst_valid = 1'b0;
    bus.i_is_syscall = 1'b0;
    bus.i_is_break   = 1'b0;
    bus.i_is_teq     = 1'b0;
    bus.i_is_eret    = 1'b0;
  endtask

  task automatic drive(input logic sys, input logic brk, input logic teq, input logic eret,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pc);
    bus.i_inst_valid = 1'b1;
    bus.i_is_syscall = sys;
    bus.i_is_break   = brk;
    bus.i_is_teq     = teq;
    bus.i_is_eret    = eret;
    bus.i_rs_val     = rs;
    bus.i_rt_val     = rt;
    bus.i_pc_in      = pc;
  endtask

  // Full exception sequence: detect N, commit N+1, vector N+2, idle N+3.
  task automatic run_exc(input string tag, input logic sys, input logic brk, input logic teq,
                         input logic eret, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc, input logic [4:0] code, input logic [2:0] dep);
    drive(sys, brk, teq, eret, rs, rt, pc);
    #1;
    chk({tag, "_stallN"}, bus.o_stall, 1);
    step();
    chk({tag, "_cause"}, bus.o_cause, code);
    chk({tag, "_excpc"}, bus.o_exc_pc, pc);
    chk({tag, "_ena"}, bus.o_cp0_ena, 1);
    chk({tag, "_redir_c"}, bus.o_redirect, 0);
    clear_in();
    step();
    chk({tag, "_redir"}, bus.o_redirect, 1);
    chk({tag, "_rpc"}, bus.o_redirect_pc, 32'h00400004);
    chk({tag, "_cause_v"}, bus.o_cause, 0);
    chk({tag, "_depth"}, bus.o_depth, dep);
    step();
    chk({tag, "_stall_end"}, bus.o_stall, 0);
    chk({tag, "_redir_end"}, bus.o_redirect, 0);
  endtask

  task automatic run_eret(input string tag, input logic [31:0] epc, input logic [2:0] dep);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd1, 32'h0);
    bus.i_epc_in = epc;
    #1;
    chk({tag, "_stallN"}, bus.o_stall, 1);
    step();
    chk({tag, "_eret"}, bus.o_eret, 1);
    chk({tag, "_ena"}, bus.o_cp0_ena, 1);
    chk({tag, "_redir"}, bus.o_redirect, 1);
    chk({tag, "_rpc"}, bus.o_redirect_pc, epc);
    clear_in();
    step();
    chk({tag, "_depth"}, bus.o_depth, dep);
    chk({tag, "_eret_end"}, bus.o_eret, 0);
    chk({tag, "_redir_end"}, bus.o_redirect, 0);
  endtask

  task automatic run_noexc(input string tag, input logic teq, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [2:0] dep);
    drive(1'b0, 1'b0, teq, 1'b0, rs, rt, 32'h00400100);
    #1;
    chk({tag, "_stall"}, bus.o_stall, 0);
    step();
    clear_in();
    chk({tag, "_cause"}, bus.o_cause, 0);
    chk({tag, "_redir"}, bus.o_redirect, 0);
    chk({tag, "_depth"}, bus.o_depth, dep);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clear_in();
    bus.i_rs_val    = 32'd0;
    bus.i_rt_val    = 32'd0;
    bus.i_pc_in     = 32'd0;
    bus.i_status_in = 32'h0000000F;
    bus.i_epc_in    = 32'd0;
`ifdef CP0_EXC_STATS_EN
    bus.i_stat_sel  = 2'd0;
`endif
    step();
    step();
    chk("rst_cause", bus.o_cause, 0);
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_redir", bus.o_redirect, 0);
    chk("rst_rpc", bus.o_redirect_pc, 0);
    chk("rst_depth", bus.o_depth, 0);
    chk("rst_ovf", bus.o_ovf, 0);
    rst = 1'b0;
    step();

    run_exc("sys", 1, 0, 0, 0, 0, 1, 32'h00400020, 5'b01000, 3'd1);
    run_exc("sysbrk", 1, 1, 0, 0, 0, 1, 32'h00400040, 5'b01000, 3'd2);
    run_exc("teq", 0, 0, 1, 0, 5, 5, 32'h00400060, 5'b01101, 3'd3);
    run_noexc("teq_ne", 1, 5, 6, 3'd3);
    bus.i_status_in = 32'h00000007;
    run_noexc("teq_mask", 1, 5, 5, 3'd3);
    bus.i_status_in = 32'h0000000F;

    run_eret("eret3", 32'h00400060, 3'd2);
    run_eret("eret2", 32'h00400040, 3'd1);
    run_eret("eret1", 32'h00400020, 3'd0);
    run_eret("eret0", 32'h00400020, 3'd0);

    // ERET alongside a qualified SYSCALL: exception path only.
    run_exc("syseret", 1, 0, 0, 1, 0, 1, 32'h00400080, 5'b01000, 3'd1);
    chk("syseret_noeret", bus.o_eret, 0);
    run_eret("eret_b", 32'h00400080, 3'd0);

    for (int i = 1; i <= 6; i++)
      run_exc($sformatf("nest%0d", i), 1, 0, 0, 0, 0, 1, 32'h00400200 + 32'(i * 4), 5'b01000, 3'(i));
    chk("pre_ovf", bus.o_ovf, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 32'h00400300);
    #1;
    chk("ovf_stall", bus.o_stall, 0);
    step();
    clear_in();
    chk("ovf_flag", bus.o_ovf, 1);
    chk("ovf_cause", bus.o_cause, 0);
    chk("ovf_depth", bus.o_depth, 6);
    step();
    chk("ovf_sticky", bus.o_ovf, 1);
    chk("ovf_redir", bus.o_redirect, 0);
`ifdef CP0_EXC_STATS_EN
    bus.i_stat_sel = 2'd0; #1; chk("stat_sys", bus.o_stat_q, 16'd9);
    bus.i_stat_sel = 2'd1; #1; chk("stat_brk", bus.o_stat_q, 16'd0);
    bus.i_stat_sel = 2'd2; #1; chk("stat_teq", bus.o_stat_q, 16'd1);
    bus.i_stat_sel = 2'd3; #1; chk("stat_drop", bus.o_stat_q, 16'd1);
    step();
`endif

    // Reset clears depth/ovf; then reset again in the middle of a COMMIT.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_ovf", bus.o_ovf, 0);
    chk("rst2_depth", bus.o_depth, 0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 32'h00400500);
    step();
    chk("mid_cause", bus.o_cause, 5'b01000);
    clear_in();
    rst = 1'b1;
    #1;
    chk("mid_rst_cause", bus.o_cause, 0);
    chk("mid_rst_excpc", bus.o_exc_pc, 0);
    chk("mid_rst_ena", bus.o_cp0_ena, 0);
    chk("mid_rst_stall", bus.o_stall, 0);
    chk("mid_rst_depth", bus.o_depth, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_redir%0d", i), bus.o_redirect, 0);
      chk($sformatf("post_rst_stall%0d", i), bus.o_stall, 0);
    end
    chk("post_rst_depth", bus.o_depth, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
